aes_round_pipe_reg: RTL and testbench

//  Registered pipeline stage between AES rounds, immediately downstream of the AddRoundKey stage.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_skid_buf.sv | 69 ++++++
 rtl/aes_round_pipe_reg.sv | 56 +++++
 tb/tb_aes_round_pipe_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES round-pipeline constants, beat layout and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int         AES_NR      = 10;
  localparam int         AES_ROUND_W = 4;
  localparam logic [7:0] AES_XPOLY   = 8'h1B;

  typedef struct packed {
    logic [127:0]           state;
    logic [127:0]           key;
    logic [7:0]             rcon;
    logic [AES_ROUND_W-1:0] round;
    logic                   empty;
  } aes_beat_t;

  function automatic logic [7:0] xtime(input logic [7:0] r, input logic [7:0] poly = AES_XPOLY);
    return {r[6:0], 1'b0} ^ (r[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives the outputs, skid catches the
// beat accepted while main is stalled, and in_ready is taken straight from a register.
module aes_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] r_main, r_skid;
  logic         r_main_v, r_skid_v, r_in_ready;
  logic [W-1:0] w_main, w_skid;
  logic         w_main_v, w_skid_v;
  logic         w_accept, w_drain;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_main_v & out_ready;

  always_comb begin
    w_main   = r_main;
    w_main_v = r_main_v;
    w_skid   = r_skid;
    w_skid_v = r_skid_v;
    // While the skid is occupied in_ready is low, so only a drain can happen.
    if (r_skid_v) begin
      if (w_drain) begin
        w_main   = r_skid;
        w_skid_v = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_v || w_drain) begin
        w_main   = in_data;
        w_main_v = 1'b1;
      end else begin
        w_skid   = in_data;
        w_skid_v = 1'b1;
      end
    end else if (w_drain) begin
      w_main_v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_main     <= w_main;
      r_skid     <= w_skid;
      r_main_v   <= w_main_v;
      r_skid_v   <= w_skid_v;
      r_in_ready <= !w_skid_v;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_v;
  assign out_data  = r_main;

endmodule

// File: rtl/aes_round_pipe_reg.sv
// Inter-round AES pipeline register: advances Rcon and the round index at capture time,
// flags the final round, and buffers beats through a two-entry skid buffer.
module aes_round_pipe_reg
  import aes_pkg::*;
#(
  parameter int         NR      = AES_NR,
  parameter int         ROUND_W = AES_ROUND_W,
  parameter logic [7:0] XPOLY   = AES_XPOLY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_state,
  input  logic [127:0]       in_key,
  input  logic [7:0]         in_rcon,
  input  logic [ROUND_W-1:0] in_round,
  input  logic               in_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_state,
  output logic [127:0]       out_key,
  output logic [7:0]         out_rcon,
  output logic [ROUND_W-1:0] out_round,
  output logic               out_empty,
  output logic               out_last
);

  localparam int PAY_W = 128 + 128 + 8 + ROUND_W + 2;

  logic [ROUND_W-1:0] w_round_inc, w_round;
  logic [7:0]         w_rcon;
  logic               w_last;
  logic [PAY_W-1:0]   w_in_data, w_out_data;

  assign w_round_inc = in_round + ROUND_W'(1);
  assign w_rcon      = in_empty ? in_rcon  : xtime(in_rcon, XPOLY);
  assign w_round     = in_empty ? in_round : w_round_inc;
  // Bubbles never count as the final round, even if their index happens to equal NR.
  assign w_last      = !in_empty && (w_round_inc == ROUND_W'(NR));
  assign w_in_data   = {in_state, in_key, w_rcon, w_round, in_empty, w_last};

  aes_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign {out_state, out_key, out_rcon, out_round, out_empty, out_last} = w_out_data;

endmodule

// File: tb/tb_aes_round_pipe_reg.sv
// Bench for aes_round_pipe_reg: directed reset/stream/backpressure/last-round/reset cases
// followed by randomized valid/ready traffic against a queue-based reference model.
module tb_aes_round_pipe_reg;

  typedef struct {
    logic [127:0] state;
    logic [127:0] key;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         empty;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic [7:0]   in_rcon;
  logic [3:0]   in_round;
  logic         in_empty;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [127:0] out_key;
  logic [7:0]   out_rcon;
  logic [3:0]   out_round;
  logic         out_empty;
  logic         out_last;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_out   = 0;
  exp_t   q[$];
  bit     rst_prev = 1'b0;
  bit     stalled_prev = 1'b0;
  logic [269:0] prev_vec = '0;

  aes_round_pipe_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_rcon   (in_rcon),
    .in_round  (in_round),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_key   (out_key),
    .out_rcon  (out_rcon),
    .out_round (out_round),
    .out_empty (out_empty),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: Rcon doubles in GF(2^8) (reduce by 0x11B on overflow), round counts mod 16.
  function automatic exp_t model(input logic [127:0] s, input logic [127:0] k,
                                 input logic [7:0] rc, input logic [3:0] rd, input logic emp);
    exp_t e;
    int   r, nr, nxt;
    e.state = s;
    e.key   = k;
    e.empty = emp;
    r   = int'(rc);
    nxt = (int'(rd) + 1) % 16;
    if (emp) begin
      e.rcon  = rc;
      e.round = rd;
      e.last  = 1'b0;
    end else begin
      nr = (r * 2) % 256;
      if (r >= 128) nr = nr ^ 27;
      e.rcon  = nr[7:0];
      e.round = nxt[3:0];
      e.last  = (nxt == 10);
    end
    return e;
  endfunction

  task automatic set_beat(input logic [3:0] rd, input logic [7:0] rc, input logic emp);
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    in_rcon  = rc;
    in_round = rd;
    in_empty = emp;
  endtask

  // One clock: check outputs at the falling edge, update the model, then advance.
  task automatic step(output bit acc);
    bit           dlv;
    exp_t         e;
    logic [269:0] cur_vec;
    @(negedge clk);
    cur_vec = {out_state, out_key, out_rcon, out_round, out_empty, out_last};
    if (!rst_prev) begin
      check("rst_in_ready", 272'(in_ready), 272'(0));
      check("rst_out_valid", 272'(out_valid), 272'(0));
      check("rst_data", 272'(cur_vec), 272'(0));
    end else begin
      check("in_ready", 272'(in_ready), 272'(q.size() < 2));
      check("out_valid", 272'(out_valid), 272'(q.size() != 0));
    end
    if (stalled_prev) check("stall_stable", 272'(cur_vec), 272'(prev_vec));
    acc = in_valid && in_ready && rst_n;
    dlv = out_valid && out_ready && rst_n;
    if (dlv && q.size() != 0) begin
      e = q.pop_front();
      check("out_state", 272'(out_state), 272'(e.state));
      check("out_key", 272'(out_key), 272'(e.key));
      check("out_rcon", 272'(out_rcon), 272'(e.rcon));
      check("out_round", 272'(out_round), 272'(e.round));
      check("out_empty", 272'(out_empty), 272'(e.empty));
      check("out_last", 272'(out_last), 272'(e.last));
      n_out++;
      $display("[TB] beat %0d out: round=%0d rcon=%h empty=%b last=%b",
               n_out, out_round, out_rcon, out_empty, out_last);
    end
    if (acc) q.push_back(model(in_state, in_key, in_rcon, in_round, in_empty));
    if (!rst_n) q.delete();
    stalled_prev = out_valid && !out_ready && rst_n;
    prev_vec = cur_vec;
    @(posedge clk);
    rst_prev = rst_n;
    #1;
  endtask

  task automatic drain(input string tag);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(acc);
    step(acc);
    check(tag, 272'(q.size()), 272'(0));
  endtask

  initial begin
    bit          acc;
    logic [7:0]  rcons [4];
    int          n_acc;
    int          cyc;

    rcons[0] = 8'h01; rcons[1] = 8'h02; rcons[2] = 8'h80; rcons[3] = 8'h1B;

    // Reset held with traffic offered.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    set_beat(4'd0, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) step(acc);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(acc);
    step(acc);
    check("ready_after_release", 272'(in_ready), 272'(1));

    // Full-throughput streaming.
    for (int i = 0; i < 4; i++) begin
      set_beat(4'(i), rcons[i], 1'b0);
      step(acc);
      check("stream_acc", 272'(acc), 272'(1));
    end
    drain("stream_drain");

    // Backpressure: A in main, B into skid, C held upstream.
    out_ready = 1'b0;
    set_beat(4'd2, 8'h04, 1'b0);
    step(acc);
    check("bp_acc_a", 272'(acc), 272'(1));
    set_beat(4'd3, 8'h08, 1'b0);
    step(acc);
    check("bp_acc_b", 272'(acc), 272'(1));
    set_beat(4'd4, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(acc);
      check("bp_c_held", 272'(acc), 272'(0));
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(acc);
    check("bp_acc_c", 272'(acc), 272'(1));
    drain("bp_drain");

    // Final round, then the same index as a bubble.
    set_beat(4'd9, 8'h36, 1'b0);
    step(acc);
    set_beat(4'd9, 8'h36, 1'b1);
    step(acc);
    set_beat(4'd15, 8'h80, 1'b0);
    step(acc);
    drain("last_drain");

    // Reset with both entries full; nothing old may emerge afterwards.
    out_ready = 1'b0;
    set_beat(4'd1, 8'h02, 1'b0);
    step(acc);
    set_beat(4'd2, 8'h04, 1'b0);
    step(acc);
    check("mid_full_ready", 272'(in_ready), 272'(0));
    rst_n = 1'b0;
    step(acc);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);
    set_beat(4'd5, 8'h20, 1'b0);
    step(acc);
    drain("mid_drain");

    // Random valid/ready traffic.
    n_acc = 0;
    cyc   = 0;
    in_valid = 1'b0;
    while (n_acc < 10000 && cyc < 60000) begin
      if (!(in_valid && !acc))
        set_beat(4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 7) == 0));
      in_valid  = ($urandom_range(0, 3) != 0) || (in_valid && !acc);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) n_acc++;
      cyc++;
    end
    check("rand_accepted", 272'(n_acc), 272'(10000));
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
